// File: rtl/crc8_frame_tx_pkg.sv
// Shared types and defaults for the CRC-8 framing transmitter.
// Holds the FSM state enum, the default polynomial and init value, and one CRC bit step.
package crc8_frame_tx_pkg;

  localparam logic [7:0] CRC8_POLY_DEFAULT = 8'h07;
  localparam logic [7:0] CRC8_INIT_DEFAULT = 8'h00;

  typedef enum logic [1:0] {
    WAIT_IN,
    CALC,
    SEND_DATA,
    SEND_CRC
  } state_t;

  // One MSB-first shift of the CRC register with the x^8 term implicit.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                           input logic       bit_in,
                                           input logic [7:0] poly);
    logic fb;
    fb = crc[7] ^ bit_in;
    return {crc[6:0], 1'b0} ^ (fb ? poly : 8'h00);
  endfunction

endpackage

// File: rtl/crc8_frame_tx_if.sv
// Byte stream bus for crc8_frame_tx: input channel (s_*) and output channel (m_*).
// The master side feeds bytes and sinks beats; the slave side is the transmitter.
interface crc8_frame_tx_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_ready;

  modport master (
    output s_data, s_valid, s_last, m_ready,
    input  s_ready, m_data, m_valid, m_last
  );

  modport slave (
    input  s_data, s_valid, s_last, m_ready,
    output s_ready, m_data, m_valid, m_last
  );
endinterface

// File: rtl/crc8_byte_engine.sv
// Bit-serial CRC-8 engine: a start pulse loads a byte, which is then shifted in MSB first
// over the next 8 edges; done is high during the cycle whose edge performs the 8th shift.
module crc8_byte_engine
  import crc8_frame_tx_pkg::*;
#(
  parameter logic [7:0] POLY = CRC8_POLY_DEFAULT,
  parameter logic [7:0] INIT = CRC8_INIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       clear,
  output logic [7:0] crc,
  output logic       done
);

  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic       active;

  // The CRC only moves while a byte is being shifted, or on an explicit clear back to INIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc     <= INIT;
      shreg   <= 8'h00;
      bit_cnt <= 3'd0;
      active  <= 1'b0;
    end else if (clear) begin
      crc <= INIT;
    end else if (start) begin
      shreg   <= data;
      bit_cnt <= 3'd0;
      active  <= 1'b1;
    end else if (active) begin
      crc     <= crc8_step(crc, shreg[7], POLY);
      shreg   <= {shreg[6:0], 1'b0};
      bit_cnt <= bit_cnt + 3'd1;
      if (bit_cnt == 3'd7) begin
        active <= 1'b0;
      end
    end
  end

  assign done = active && (bit_cnt == 3'd7);

endmodule

// File: rtl/crc8_frame_tx.sv
// CRC-8 frame transmitter: echoes each payload byte after an 8-cycle bit-serial CRC update
// and appends the CRC byte (m_last = 1) after the byte that carried s_last.
module crc8_frame_tx
  import crc8_frame_tx_pkg::*;
#(
  parameter logic [7:0] POLY = CRC8_POLY_DEFAULT,
  parameter logic [7:0] INIT = CRC8_INIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  crc8_frame_tx_if.slave       bus,
  output logic                 busy
);

  state_t     state;
  state_t     next_state;
  logic [7:0] data_reg;
  logic       last_reg;
  logic       start;
  logic       clear;
  logic       done;
  logic [7:0] crc;

  // The input is only ever accepted in WAIT_IN, so s_ready is implied by the state.
  assign start = (state == WAIT_IN) && bus.s_valid;

  crc8_byte_engine #(
    .POLY (POLY),
    .INIT (INIT)
  ) u_engine (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .data  (bus.s_data),
    .clear (clear),
    .crc   (crc),
    .done  (done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= WAIT_IN;
      data_reg <= 8'h00;
      last_reg <= 1'b0;
    end else begin
      state <= next_state;
      if (start) begin
        data_reg <= bus.s_data;
        last_reg <= bus.s_last;
      end
    end
  end

  always_comb begin
    next_state  = state;
    bus.s_ready = 1'b0;
    bus.m_valid = 1'b0;
    bus.m_last  = 1'b0;
    bus.m_data  = 8'h00;
    busy        = 1'b1;
    clear       = 1'b0;
    case (state)
      WAIT_IN: begin
        bus.s_ready = 1'b1;
        busy        = 1'b0;
        if (bus.s_valid) begin
          next_state = CALC;
        end
      end
      CALC: begin
        if (done) begin
          next_state = SEND_DATA;
        end
      end
      SEND_DATA: begin
        bus.m_valid = 1'b1;
        bus.m_data  = data_reg;
        if (bus.m_ready) begin
          next_state = last_reg ? SEND_CRC : WAIT_IN;
        end
      end
      SEND_CRC: begin
        bus.m_valid = 1'b1;
        bus.m_data  = crc;
        bus.m_last  = 1'b1;
        if (bus.m_ready) begin
          clear      = 1'b1;
          next_state = WAIT_IN;
        end
      end
      default: begin
        next_state = WAIT_IN;
      end
    endcase
  end

endmodule

// File: tb/tb_crc8_frame_tx.sv
// Self-checking bench for crc8_frame_tx: directed and random frames compared against a
// bytewise CRC-8 reference model; beats are logged by a monitor and matched in order.
module tb_crc8_frame_tx;
  import crc8_frame_tx_pkg::*;

  localparam logic [7:0] POLY = 8'h07;
  localparam logic [7:0] INIT = 8'h00;

  logic clk;
  logic rst_n;
  logic busy;
  crc8_frame_tx_if bus ();

  crc8_frame_tx #(
    .POLY (POLY),
    .INIT (INIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy)
  );

  int errors = 0;
  int checks = 0;
  bit rand_ready = 0;

  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs only change 1ns after a rising edge, so the negedge sample sees the handshake.
  always @(negedge clk) begin
    if (rst_n && bus.m_valid && bus.m_ready) begin
      obs_q.push_back({bus.m_last, bus.m_data});
    end
  end

  function automatic logic [7:0] crc_ref(input logic [7:0] f[$]);
    logic [7:0] c;
    c = INIT;
    foreach (f[i]) begin
      c = c ^ f[i];
      for (int k = 0; k < 8; k++) begin
        c = c[7] ? ((c << 1) ^ POLY) : (c << 1);
      end
    end
    return c;
  endfunction

  function automatic void add_frame(input logic [7:0] f[$]);
    foreach (f[i]) exp_q.push_back({1'b0, f[i]});
    exp_q.push_back({1'b1, crc_ref(f)});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) bus.m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int guard = 0;
    while (!bus.s_ready && guard < 500) begin
      tick();
      guard++;
    end
    if (!bus.s_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL send_timeout s_ready=%b required=1", bus.s_ready);
    end
    bus.s_data  = d;
    bus.s_last  = l;
    bus.s_valid = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    bus.s_data  = 8'($urandom);
    bus.s_last  = 1'($urandom);
  endtask

  task automatic send_frame(input logic [7:0] f[$]);
    foreach (f[i]) send_byte(f[i], (i == f.size() - 1));
  endtask

  task automatic wait_beats();
    int guard = 0;
    while (obs_q.size() < exp_q.size() && guard < 3000) begin
      tick();
      guard++;
    end
    if (obs_q.size() < exp_q.size()) begin
      checks++;
      errors++;
      $display("[TB] FAIL beat_timeout got=%0d beats required=%0d", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.s_data = 8'h00; bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.m_ready = 1'b0;
    #12;
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_m_valid got=%b exp=0", bus.m_valid); end
    checks++; if (bus.m_last !== 1'b0) begin errors++; $display("[TB] FAIL rst_m_last got=%b exp=0", bus.m_last); end
    checks++; if (bus.m_data !== 8'h00) begin errors++; $display("[TB] FAIL rst_m_data got=%h exp=00", bus.m_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got=%b exp=0", busy); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_s_ready got=%b exp=1", bus.s_ready); end
  endtask

  task automatic test_single_byte();
    logic [7:0] f[$];
    int base = exp_q.size();
    bus.m_ready = 1'b1;
    f = '{8'h01};
    add_frame(f);
    checks++; if (exp_q[exp_q.size()-1] !== {1'b1, 8'h07}) begin errors++; $display("[TB] FAIL model_crc01 got=%h exp=107", exp_q[exp_q.size()-1]); end
    send_frame(f);
    wait_beats();
    for (int i = base; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL single_beat%0d got=%h exp=%h", i - base, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_check_string();
    logic [7:0] f[$];
    int base = exp_q.size();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 9; i++) f.push_back(8'h31 + 8'(i));
    add_frame(f);
    checks++; if (exp_q[exp_q.size()-1] !== {1'b1, 8'hF4}) begin errors++; $display("[TB] FAIL model_check got=%h exp=1f4", exp_q[exp_q.size()-1]); end
    send_frame(f);
    wait_beats();
    for (int i = base; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL string_beat%0d got=%h exp=%h", i - base, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] f[$];
    int base = exp_q.size();
    bus.m_ready = 1'b1;
    f = '{8'h01};
    add_frame(f);
    add_frame(f);
    send_frame(f);
    send_frame(f);
    wait_beats();
    for (int i = base; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL b2b_beat%0d got=%h exp=%h", i - base, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] f[$];
    logic [7:0] c;
    int guard = 0;
    int base = exp_q.size();
    f = '{8'h5A};
    c = crc_ref(f);
    add_frame(f);
    bus.m_ready = 1'b0;
    send_byte(8'h5A, 1'b1);
    while (!bus.m_valid && guard < 50) begin tick(); guard++; end
    checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid_timeout got=%b exp=1", bus.m_valid); end
    bus.s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.s_data = 8'($urandom);
      checks++;
      if (bus.m_data !== 8'h5A || bus.m_last !== 1'b0 || bus.s_ready !== 1'b0)
        begin errors++; $display("[TB] FAIL bp_data_hold%0d got=%h/%b/%b exp=5a/0/0", i, bus.m_data, bus.m_last, bus.s_ready); end
      tick();
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.m_data !== c || bus.m_last !== 1'b1 || bus.s_ready !== 1'b0 || bus.m_valid !== 1'b1)
        begin errors++; $display("[TB] FAIL bp_crc_hold%0d got=%h/%b/%b exp=%h/1/0", i, bus.m_data, bus.m_last, bus.s_ready, c); end
      tick();
    end
    bus.m_ready = 1'b1;
    tick();
    tick();
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL bp_beat_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = base; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL bp_beat%0d got=%h exp=%h", i - base, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] f[$];
    int base = exp_q.size();
    bus.m_ready = 1'b1;
    send_byte(8'hFF, 1'b1);
    tick();
    tick();
    rst_n = 1'b0;
    #2;
    checks++; if (busy !== 1'b0 || bus.m_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_async got=%b/%b exp=0/0", busy, bus.m_valid); end
    tick();
    tick();
    rst_n = 1'b1;
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_s_ready got=%b exp=1", bus.s_ready); end
    f = '{8'h01};
    add_frame(f);
    send_frame(f);
    wait_beats();
    tick();
    tick();
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL midrst_beat_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = base; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL midrst_beat%0d got=%h exp=%h", i - base, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_latency();
    logic [7:0] f[$];
    int cnt = 0;
    int base = exp_q.size();
    bus.m_ready = 1'b1;
    f = '{8'hA5, 8'h3C};
    add_frame(f);
    send_byte(8'hA5, 1'b0);
    while (!bus.m_valid && cnt < 20) begin tick(); cnt++; end
    checks++; if (cnt !== 8) begin errors++; $display("[TB] FAIL latency got=%0d edges exp=8", cnt); end
    tick();
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_beat got=%b exp=1", bus.s_ready); end
    send_byte(8'h3C, 1'b1);
    wait_beats();
    for (int i = base; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL lat_beat%0d got=%h exp=%h", i - base, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random_frames();
    logic [7:0] f[$];
    int base = exp_q.size();
    rand_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      f.delete();
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) f.push_back(8'($urandom));
      add_frame(f);
      send_frame(f);
    end
    wait_beats();
    rand_ready = 1'b0;
    bus.m_ready = 1'b1;
    tick();
    tick();
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL rand_beat_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = base; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL rand_beat%0d got=%h exp=%h", i - base, obs_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_check_string();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_frame();
    test_latency();
    test_random_frames();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard bound on run time so a stuck design still ends with a report.
  initial begin
    #400000;
    $display("[TB] FAIL global_timeout got=running exp=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/crc8_frame_tx.md
CRC8_FRAME_TX -- requirements
Module: crc8_frame_tx

Interface
REQ-001 The block SHALL have parameter POLY, default 8'h07, CRC-8 generator polynomial with the x^8 term implicit.
REQ-002 The block SHALL have parameter INIT, default 8'h00, CRC register value at the start of every frame.
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port s_data, input, 8 bits: payload byte in.
REQ-006 The block SHALL have port s_valid, input, 1 bit: s_data/s_last valid.
REQ-007 The block SHALL have port s_last, input, 1 bit: byte is the final payload byte of the frame.
REQ-008 The block SHALL have port s_ready, output, 1 bit: block accepts a byte this cycle.
REQ-009 The block SHALL have port m_data, output, 8 bits: payload byte or CRC byte out.
REQ-010 The block SHALL have port m_valid, output, 1 bit: m_data/m_last valid.
REQ-011 The block SHALL have port m_last, output, 1 bit: m_data is the appended CRC byte.
REQ-012 The block SHALL have port m_ready, input, 1 bit: downstream accepts m_data.
REQ-013 The block SHALL have port busy, output, 1 bit: high in any state other than WAIT_IN.

Function
REQ-014 The FSM SHALL have states WAIT_IN, CALC, SEND_DATA and SEND_CRC.
REQ-015 Input handshake: a byte is accepted when s_valid && s_ready; s_ready = 1 only in WAIT_IN.
REQ-016 Output handshake: a beat completes when m_valid && m_ready; m_valid = 1 only in SEND_DATA or SEND_CRC.
REQ-017 While m_valid = 1 and m_ready = 0, m_data and m_last SHALL hold stable.
REQ-018 WAIT_IN -> CALC on accept; the accepting edge SHALL capture s_data and s_last and load bit counter = 0.
REQ-019 CALC SHALL last exactly 8 cycles, shifting one captured bit per edge, MSB first.
- Per bit b: fb = crc[7] ^ b; crc <= {crc[6:0],1'b0} ^ (fb ? POLY : 8'h00).
REQ-020 CALC -> SEND_DATA on the 8th shift edge; m_valid SHALL be visible 8 edges after the accepting edge.
REQ-021 In SEND_DATA, m_data SHALL be the captured byte, unmodified, with m_last = 0.
REQ-022 On SEND_DATA completion: go to SEND_CRC if the captured s_last = 1, else to WAIT_IN.
REQ-023 In SEND_CRC, m_data SHALL be the CRC register with m_last = 1.
REQ-024 On SEND_CRC completion the block SHALL load crc = INIT and go to WAIT_IN; the next byte starts a new frame.
REQ-025 The CRC register SHALL NOT change outside CALC, except for the INIT load on SEND_CRC completion.
REQ-026 No zero-length frames: every frame SHALL carry at least one payload byte; frame end is signalled only by s_last on a payload byte.
REQ-027 s_data/s_last changes while s_ready = 0 SHALL be ignored.
REQ-028 Throughput SHALL be 1 byte per 10 cycles with m_ready held 1; each frame adds 1 CRC beat.

Reset
REQ-029 rst_n low SHALL, asynchronously, set:
- state = WAIT_IN
- crc = INIT
- bit counter = 0
- captured byte and last flag = 0
- m_valid = 0, m_last = 0, m_data = 8'h00
- busy = 0
REQ-030 Reset mid-frame (any state) SHALL discard the partial frame; the first byte after release starts a new frame with crc = INIT.
REQ-031 s_ready SHALL be 1 on the first cycle after rst_n deasserts.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, CRC8_POLY_DEFAULT = 8'h07 and CRC8_INIT_DEFAULT = 8'h00.
REQ-033 The bit-serial shift SHALL sit in one sub-module, crc8_byte_engine.
- Inputs: start pulse, byte, clear.
- Outputs: crc[7:0], one-cycle done pulse on the 8th shift.
- Top module: FSM and handshakes only.

Verification
REQ-034 Single byte 8'h01, s_last = 1, m_ready = 1 -> beat 8'h01 (m_last = 0), then beat 8'h07 (m_last = 1).
REQ-035 Frame ASCII "123456789" (8'h31..8'h39), last on 8'h39 -> 9 data beats echoed, then CRC beat 8'hF4 with m_last = 1.
REQ-036 Two back-to-back frames {8'h01}, {8'h01} -> both CRC beats = 8'h07 (proves INIT reload).
REQ-037 m_ready = 0 for 5 cycles during SEND_DATA and during SEND_CRC:
- m_data and m_last held stable; s_ready = 0 throughout.
- No beat lost or duplicated.
REQ-038 rst_n pulsed low during CALC of byte 8'hFF, then frame {8'h01} -> CRC beat 8'h07; no stale output beat.
REQ-039 Latency check: accept at edge N -> m_valid first high after edge N+8; s_ready high again the cycle after the data beat completes.
